// File: rtl/imem_arbiter_if.sv
// Core-side fetch bus of the shared instruction-memory arbiter: two request
// channels plus their grants and registered read-data returns.
interface imem_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic [0:ADDR_W-1] addr0;
  logic [0:ADDR_W-1] addr1;
  logic              gnt0;
  logic              gnt1;
  logic [0:DATA_W-1] rdata0;
  logic [0:DATA_W-1] rdata1;
  logic              rvalid0;
  logic              rvalid1;

  // master = the two cores, slave = the arbiter
  modport master (
    output req0, req1, addr0, addr1,
    input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1
  );

  modport slave (
    input  req0, req1, addr0, addr1,
    output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1
  );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one asynchronous-read instruction memory between
// two cores, with registered read-data return and a saturating conflict counter.
module imem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  imem_arbiter_if.slave     bus,
  output logic [0:ADDR_W-1] o_imem_addr,
  input  logic [0:DATA_W-1] i_imem_data,
  output logic [0:CNT_W-1]  o_conflict_cnt
);

  typedef enum logic {
    LAST_CORE0 = 1'b0,
    LAST_CORE1 = 1'b1
  } last_e;

  last_e             r_last;
  last_e             w_last_nxt;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_both;
  logic [0:DATA_W-1] r_rdata0;
  logic [0:DATA_W-1] r_rdata1;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [0:CNT_W-1]  r_conflict_cnt;

  assign w_both = bus.req0 & bus.req1;

  // Most-recent-winner register; reset to core 1 so core 0 takes the first tie
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last <= LAST_CORE1;
    end else begin
      r_last <= w_last_nxt;
    end
  end

  // Grant decode and next most-recent-winner; grants depend only on req/reset/last
  always_comb begin
    w_gnt0     = 1'b0;
    w_gnt1     = 1'b0;
    w_last_nxt = r_last;
    if (i_reset) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end else begin
      case ({bus.req0, bus.req1})
        2'b10:   w_gnt0 = 1'b1;
        2'b01:   w_gnt1 = 1'b1;
        2'b11: begin
          if (r_last == LAST_CORE1) begin
            w_gnt0 = 1'b1;
          end else begin
            w_gnt1 = 1'b1;
          end
        end
        default: begin
          w_gnt0 = 1'b0;
          w_gnt1 = 1'b0;
        end
      endcase
    end
    if (w_gnt0) begin
      w_last_nxt = LAST_CORE0;
    end else if (w_gnt1) begin
      w_last_nxt = LAST_CORE1;
    end else begin
      w_last_nxt = r_last;
    end
  end

  // Idle cycles present addr0 so the memory address is never undefined
  assign o_imem_addr = w_gnt1 ? bus.addr1 : bus.addr0;

  // Capture the memory word for the winner; the loser's data holds
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdata0  <= {DATA_W{1'b0}};
      r_rdata1  <= {DATA_W{1'b0}};
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0;
      r_rvalid1 <= w_gnt1;
      if (w_gnt0) begin
        r_rdata0 <= i_imem_data;
      end
      if (w_gnt1) begin
        r_rdata1 <= i_imem_data;
      end
    end
  end

  // Saturating count of both-requesting cycles
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_conflict_cnt <= {CNT_W{1'b0}};
    end else if (w_both && (r_conflict_cnt != {CNT_W{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_conflict_cnt <= r_conflict_cnt;
    end
  end

  assign bus.gnt0       = w_gnt0;
  assign bus.gnt1       = w_gnt1;
  assign bus.rdata0     = r_rdata0;
  assign bus.rdata1     = r_rdata1;
  assign bus.rvalid0    = r_rvalid0;
  assign bus.rvalid1    = r_rvalid1;
  assign o_conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: a reference arbitration model pushes
// expected words into per-core queues, popped when the DUT returns data.
module tb_imem_arbiter;
  localparam int AW   = 9;
  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [0:AW-1] imem_addr;
  logic [0:DW-1] imem_data;
  logic [0:CW-1] conflict_cnt;
  logic [DW-1:0] mem [512];

  assign imem_data = mem[imem_addr];

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .bus            (bus),
    .o_imem_addr    (imem_addr),
    .i_imem_data    (imem_data),
    .o_conflict_cnt (conflict_cnt)
  );

  int          total = 0;
  int          bad   = 0;
  logic        m_last;
  int          m_cnt;
  logic [31:0] m_rd0, m_rd1;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One bus cycle: drive, check combinational outputs, advance model, check registers
  task automatic step(input logic rst, input logic r0, input logic [8:0] a0,
                      input logic r1, input logic [8:0] a1);
    logic e_g0, e_g1;
    @(negedge clk);
    reset     = rst;
    bus.req0  = r0;
    bus.addr0 = a0;
    bus.req1  = r1;
    bus.addr1 = a1;
    #1;
    e_g0 = !rst && r0 && (!r1 || m_last);
    e_g1 = !rst && r1 && (!r0 || !m_last);
    check_eq("gnt0", 32'(bus.gnt0), 32'(e_g0));
    check_eq("gnt1", 32'(bus.gnt1), 32'(e_g1));
    check_eq("imem_addr", 32'(imem_addr), e_g1 ? 32'(a1) : 32'(a0));
    if (e_g0) begin
      q0.push_back(mem[a0]);
      m_last = 1'b0;
    end else if (e_g1) begin
      q1.push_back(mem[a1]);
      m_last = 1'b1;
    end
    if (rst) begin
      m_last = 1'b1;
      m_cnt  = 0;
      m_rd0  = 32'h0;
      m_rd1  = 32'h0;
    end else if (r0 && r1 && m_cnt < CMAX) begin
      m_cnt++;
    end
    @(posedge clk);
    #1;
    check_eq("rvalid0", 32'(bus.rvalid0), 32'(e_g0));
    check_eq("rvalid1", 32'(bus.rvalid1), 32'(e_g1));
    if (bus.rvalid0 && q0.size() > 0) m_rd0 = q0.pop_front();
    if (bus.rvalid1 && q1.size() > 0) m_rd1 = q1.pop_front();
    check_eq("rdata0", 32'(bus.rdata0), m_rd0);
    check_eq("rdata1", 32'(bus.rdata1), m_rd1);
    check_eq("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h5A000000 ^ (32'(i) * 32'h00010203);
    mem[5] = 32'hDEADBEEF;
    m_last = 1'b1;
    m_cnt  = 0;
    m_rd0  = 32'h0;
    m_rd1  = 32'h0;

    // reset held two cycles with both cores requesting, then tie goes to core 0
    step(1'b1, 1'b1, 9'd1, 1'b1, 9'd2);
    step(1'b1, 1'b1, 9'd1, 1'b1, 9'd2);
    step(1'b0, 1'b1, 9'd1, 1'b1, 9'd2);
    step(1'b0, 1'b0, 9'd0, 1'b0, 9'd0);

    // single requester, then rdata0 must hold through idle cycles
    step(1'b0, 1'b1, 9'd5, 1'b0, 9'd0);
    step(1'b0, 1'b0, 9'd0, 1'b0, 9'd0);
    step(1'b0, 1'b0, 9'd0, 1'b0, 9'd0);

    // contention from a fresh reset: alternate 0,1,0,1,0,1 and count 6
    step(1'b1, 1'b0, 9'd0, 1'b0, 9'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 9'd10, 1'b1, 9'd20);
    step(1'b0, 1'b0, 9'd0, 1'b0, 9'd0);

    // core 1 streaming through the top of memory
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 9'd0, 1'b1, 9'(9'h1FC + i));
    step(1'b0, 1'b0, 9'd0, 1'b0, 9'd0);

    // reset right after a core-1 grant; the following tie must go to core 0
    step(1'b0, 1'b0, 9'd0, 1'b1, 9'd7);
    step(1'b1, 1'b1, 9'd8, 1'b1, 9'd9);
    step(1'b0, 1'b1, 9'd3, 1'b1, 9'd4);
    step(1'b0, 1'b0, 9'd0, 1'b0, 9'd0);

    // saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 9'(30 + i), 1'b1, 9'(100 + i));
    check_eq("cnt_saturated", 32'(conflict_cnt), 32'(CMAX));
    step(1'b0, 1'b0, 9'd0, 1'b0, 9'd0);

    check_eq("q0_leftover", 32'(q0.size()), 32'd0);
    check_eq("q1_leftover", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
